// File: rtl/pio_uart_pkg.sv
// Shared definitions for the PIO-compatible UART transmitter: FSM states,
// divider width and the idle line level.
package pio_uart_pkg;

    localparam int   DIV_W      = 16;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with asynchronous reset; full/empty flags are
// registered from the next-state occupancy so they settle right after each edge.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic             doPush, doPop;

    // A push on a full FIFO is only accepted when a pop frees a slot on the same edge.
    assign doPop  = pop_i && !empty_q;
    assign doPush = push_i && (!full_q || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered, idle-high, start + LSB-first data + stop.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
    import pio_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     div,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 push,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 busy,
    output logic                 tx
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     baudCnt_q, baudCnt_d;
    logic [DIV_W-1:0]     reload_q, reload_d;
    logic [3:0]           bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 fifoEmpty;
    logic [DATA_BITS-1:0] fifoHead;
    logic                 pop;
    logic                 bitEnd;
    logic                 loadFrame;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (din),
        .pop_i   (pop),
        .head_o  (fifoHead),
        .full_o  (tx_full),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        reload_d  = reload_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bitEnd    = (baudCnt_q == '0);

        if (state_q != ST_IDLE) begin
            baudCnt_d = bitEnd ? reload_q : baudCnt_q - DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
            end
            ST_START: begin
                if (bitEnd) begin
                    state_d  = ST_DATA;
                    tx_d     = shift_q[0];
                    bitCnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bitEnd) begin
                    if (bitCnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bitEnd) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (bitEnd) begin
                    state_d = ST_IDLE;
                    tx_d    = IDLE_LEVEL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase

        // Starting a frame from IDLE or straight out of a finished stop bit
        // overrides the above, so back-to-back frames have no idle gap.
        loadFrame = !fifoEmpty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bitEnd));
        pop       = loadFrame;
        if (loadFrame) begin
            shift_d   = fifoHead;
            reload_d  = div;
            baudCnt_d = div;
            tx_d      = 1'b0;
            state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifoHead;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            reload_q  <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            reload_q  <= reload_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_empty = fifoEmpty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a scoreboard of expected bytes/divisors is
// filled when bytes are pushed and consumed by a line monitor decoding tx.
module tb_uart_tx;

    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [15:0] div;
    logic [7:0]  din;
    logic        push;
    logic        tx_full;
    logic        tx_empty;
    logic        busy;
    logic        tx;

    entry_t sb[$];
    int     startLog[$];
    int     checkCount = 0;
    int     errorCount = 0;
    int     cycleCnt = 0;
    int     frameCount = 0;
    int     lastPushCycle = 0;
    bit     monEnable = 1'b0;
    bit     monBusy = 1'b0;

    uart_tx #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .din      (din),
        .push     (push),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .busy     (busy),
        .tx       (tx)
    );

    // Free-running clock and an edge counter used to time frame starts.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line level the reference frame should show during bit slot idx.
    function automatic logic expBit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Pushes one byte on the next edge; accepted bytes join the scoreboard.
    task automatic applyStimulus(input logic [7:0] data, input int expDiv, input bit accepted);
        entry_t e;
        din  = data;
        push = 1'b1;
        if (accepted) begin
            e.data = data;
            e.div  = expDiv;
            sb.push_back(e);
        end
        @(negedge clk);
        lastPushCycle = cycleCnt;
        push = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !monBusy && tx_empty && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Cycle-exact frame monitor: every cycle of the frame is compared with the
    // reference waveform and the data byte is recovered at mid-bit.
    initial begin : monitor
        entry_t     e;
        int         d, total, bad;
        bit         aborted;
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (monEnable && !reset && tx == 1'b0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_frame", 1, 0);
                    e.data = 8'h00;
                    e.div  = int'(div);
                end else begin
                    e = sb.pop_front();
                end
                monBusy = 1'b1;
                startLog.push_back(cycleCnt);
                frameCount++;
                d       = e.div + 1;
                total   = FRAME_BITS * d;
                bad     = 0;
                rx      = '0;
                aborted = 1'b0;
                for (int c = 0; c < total; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== expBit(e.data, c / d)) bad++;
                    if (busy !== 1'b1) bad++;
                    if ((c % d) == (d - 1) / 2 && (c / d) >= 1 && (c / d) <= DB) rx[c/d-1] = tx;
                end
                if (!aborted) begin
                    checkOutput("frame_data", rx, e.data);
                    checkOutput("frame_cycle_errors", bad, 0);
                end
                monBusy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int badTx, badBusy, badEmpty, n;

        reset = 1'b1;
        push  = 1'b0;
        din   = '0;
        div   = 16'd9;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_empty", tx_empty, 1);
        checkOutput("reset_full", tx_full, 0);
        reset = 1'b0;

        // Idle line after reset release.
        badTx = 0; badBusy = 0; badEmpty = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) badTx++;
            if (busy !== 1'b0) badBusy++;
            if (tx_empty !== 1'b1) badEmpty++;
        end
        checkOutput("idle_tx_errors", badTx, 0);
        checkOutput("idle_busy_errors", badBusy, 0);
        checkOutput("idle_empty_errors", badEmpty, 0);

        monEnable = 1'b1;

        // Single 0x55 frame at div=9, including first-push latency.
        $display("[TB] single frame 0x55 div=9");
        startLog.delete();
        div = 16'd9;
        applyStimulus(8'h55, 9, 1'b1);
        checkOutput("push_empty_clear", tx_empty, 0);
        checkOutput("push_busy_still_low", busy, 0);
        waitDrain(400);
        if (startLog.size() >= 1) checkOutput("start_latency", startLog[0] - lastPushCycle, 1);
        else checkOutput("start_seen", 0, 1);

        // Back-to-back frames at div=0.
        $display("[TB] back-to-back 0xA3 0x0F div=0");
        startLog.delete();
        div = 16'd0;
        applyStimulus(8'hA3, 0, 1'b1);
        applyStimulus(8'h0F, 0, 1'b1);
        waitDrain(200);
        if (startLog.size() >= 2) checkOutput("b2b_gap", startLog[1] - startLog[0], FRAME_BITS);
        else checkOutput("b2b_frames_seen", startLog.size(), 2);

        // FIFO fill with a dropped sixth push.
        $display("[TB] fifo fill div=100");
        n = frameCount;
        div = 16'd100;
        applyStimulus(8'h11, 100, 1'b1);
        applyStimulus(8'h22, 100, 1'b1);
        applyStimulus(8'h33, 100, 1'b1);
        applyStimulus(8'h44, 100, 1'b1);
        checkOutput("fill_not_full_at_3", tx_full, 0);
        applyStimulus(8'h5A, 100, 1'b1);
        checkOutput("fill_full_at_4", tx_full, 1);
        applyStimulus(8'hEE, 100, 1'b0);
        checkOutput("fill_full_after_drop", tx_full, 1);
        waitDrain(7000);
        checkOutput("fill_frame_count", frameCount - n, 5);

        // Divider change mid-frame only affects the next frame.
        $display("[TB] divider change 9 -> 3");
        startLog.delete();
        div = 16'd9;
        applyStimulus(8'hC6, 9, 1'b1);
        applyStimulus(8'h39, 3, 1'b1);
        repeat (30) @(negedge clk);
        div = 16'd3;
        waitDrain(400);
        if (startLog.size() >= 2) checkOutput("div_change_first_len", startLog[1] - startLog[0], FRAME_BITS * 10);
        else checkOutput("div_change_frames_seen", startLog.size(), 2);

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has odd weight so the parity bit is 1.
        $display("[TB] parity frame 0x07 div=1");
        startLog.delete();
        div = 16'd1;
        applyStimulus(8'h07, 1, 1'b1);
        waitDrain(100);
        checkOutput("parity_frames_seen", startLog.size(), 1);
`endif

        // Reset mid-frame forces the line high and drops queued bytes.
        $display("[TB] reset mid-frame");
        monEnable = 1'b0;
        div = 16'd9;
        applyStimulus(8'hF0, 9, 1'b0);
        applyStimulus(8'hAA, 9, 1'b0);
        repeat (24) @(negedge clk);
        checkOutput("midframe_tx_low", tx, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_tx", tx, 1);
        checkOutput("reset_async_busy", busy, 0);
        checkOutput("reset_async_empty", tx_empty, 1);
        @(negedge clk);
        reset = 1'b0;
        badTx = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) badTx++;
        end
        checkOutput("post_reset_idle_errors", badTx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
